// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
// State encodings are reused by every stage register flavour.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_FULL  = 2'd1;
  localparam logic [1:0] CNT_SKID  = 2'd2;

  function automatic logic [1:0] state_count(
    input stage_state_e s
  );
    unique case (s)
      ST_FULL: state_count = CNT_FULL;
      ST_SKID: state_count = CNT_SKID;
      default: state_count = CNT_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register: skid-buffered
// (registered o_ready) or single-entry (combinational o_ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH  = 32,
  parameter logic [WIDTH-1:0]  BUBBLE = '0,
  parameter bit                SKID   = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  generate
    if (SKID) begin : g_skid
      stage_state_e     state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             ready_q, ready_d;
      logic             in_fire;
      logic             out_fire;

      assign in_fire  = i_valid & ready_q;
      assign out_fire = i_ready & (state_q != ST_EMPTY);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_FULL;
              main_d  = i_data;
            end
          end
          ST_FULL: begin
            unique case ({in_fire, out_fire})
              2'b01: state_d = ST_EMPTY;
              2'b11: main_d  = i_data;
              2'b10: begin
                state_d = ST_SKID;
                skid_d  = i_data;
              end
              default: ;
            endcase
          end
          ST_SKID: begin
            if (out_fire) begin
              state_d = ST_FULL;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        // Flush wins over every handshake on the same edge.
        if (i_flush) begin
          state_d = ST_EMPTY;
        end
        ready_d = (state_d != ST_SKID);
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          state_q <= ST_EMPTY;
          main_q  <= BUBBLE;
          skid_q  <= BUBBLE;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          ready_q <= ready_d;
        end
      end

      assign o_ready = ready_q;
      assign o_valid = (state_q != ST_EMPTY);
      assign o_data  = o_valid ? main_q : BUBBLE;
      assign o_count = state_count(state_q);
    end else begin : g_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic             ready;

      assign ready = i_ready | ~valid_q;

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_valid && ready) begin
          valid_d = 1'b1;
          data_d  = i_data;
        end else if (i_ready) begin
          valid_d = 1'b0;
        end
        if (i_flush) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          valid_q <= 1'b0;
          data_q  <= BUBBLE;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign o_ready = ready;
      assign o_valid = valid_q;
      assign o_data  = valid_q ? data_q : BUBBLE;
      assign o_count = {1'b0, valid_q};
    end
  endgenerate

endmodule
